// File: rtl/phyreg_free_list.sv
// Free list of physical register IDs between ROB commit (release) and rename (allocate).
// Optional same-cycle release-to-allocate bypass on an empty list: define FREE_LIST_BYPASS_EN.
module phyreg_free_list #(
  parameter  int NUM_PHYREG  = 128,
  parameter  int NUM_ARCHREG = 32,
  localparam int FREE_DEPTH  = NUM_PHYREG - NUM_ARCHREG,
  localparam int PHY_W       = $clog2(NUM_PHYREG),
  localparam int CNT_W       = $clog2(NUM_PHYREG) + 1
) (
  input  logic             SIG_CLK,
  input  logic             SIG_RSTn,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [PHY_W-1:0] alloc_id,
  input  logic             rel_valid,
  output logic             rel_ready,
  input  logic [PHY_W-1:0] rel_id,
  output logic [CNT_W-1:0] free_count,
  output logic             init_done,
  output logic             dup_err
);

  localparam logic [PHY_W-1:0] PTR_LAST  = PHY_W'(FREE_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FREE_DEPTH);
  localparam logic [PHY_W-1:0] ARCH_BASE = PHY_W'(NUM_ARCHREG);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state;
  logic [PHY_W-1:0]      fifo [FREE_DEPTH];
  logic [PHY_W-1:0]      rd_ptr;
  logic [PHY_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [NUM_PHYREG-1:0] bitmap;
  logic [NUM_PHYREG-1:0] bitmap_eff;
  logic [NUM_PHYREG-1:0] bitmap_nxt;
  logic                  init_done_q;
  logic                  dup_err_q;

  logic                  run;
  logic                  not_empty;
  logic                  fifo_gnt;
  logic [PHY_W-1:0]      head_id;
  logic [PHY_W-1:0]      init_id;
  logic                  rel_take;
  logic                  rel_bad;
  logic                  fifo_full;
  logic                  bypass;
  logic                  rel_ok;
  logic                  rel_dup;

  // Pointers wrap at FREE_DEPTH, which need not be a power of two.
  function automatic logic [PHY_W-1:0] next_ptr(input logic [PHY_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign run       = (state == S_RUN);
  assign not_empty = (count != '0);
  assign head_id   = fifo[rd_ptr];
  assign init_id   = ARCH_BASE + wr_ptr;
  assign fifo_gnt  = run && alloc_req && not_empty;

  // A release is judged against the bitmap after this cycle's grant has cleared its bit,
  // so the head ID can be allocated and returned in the same cycle.
  always_comb begin
    bitmap_eff = bitmap;
    if (fifo_gnt) bitmap_eff[head_id] = 1'b0;
    bitmap_nxt = bitmap_eff;
    if (rel_ok) bitmap_nxt[rel_id] = 1'b1;
  end

  assign rel_take  = run && rel_valid;
  assign rel_bad   = (rel_id == '0) || bitmap_eff[rel_id];
  assign fifo_full = (count == DEPTH_CNT) && !fifo_gnt;

`ifdef FREE_LIST_BYPASS_EN
  assign bypass = run && alloc_req && !not_empty && rel_valid && !rel_bad;
`else
  assign bypass = 1'b0;
`endif

  assign rel_ok  = rel_take && !rel_bad && !fifo_full && !bypass;
  assign rel_dup = rel_take && !bypass && (rel_bad || fifo_full);

  assign alloc_gnt  = fifo_gnt || bypass;
  assign alloc_id   = bypass ? rel_id : (run ? head_id : '0);
  assign rel_ready  = init_done_q;
  assign init_done  = init_done_q;
  assign free_count = count;
  assign dup_err    = dup_err_q;

  always_ff @(posedge SIG_CLK or negedge SIG_RSTn) begin
    if (!SIG_RSTn) begin
      state       <= S_INIT;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      bitmap      <= '0;
      init_done_q <= 1'b0;
      dup_err_q   <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          bitmap[init_id] <= 1'b1;
          wr_ptr          <= next_ptr(wr_ptr);
          count           <= count + 1'b1;
          if (wr_ptr == PTR_LAST) begin
            state       <= S_RUN;
            init_done_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (fifo_gnt) rd_ptr <= next_ptr(rd_ptr);
          if (rel_ok)   wr_ptr <= next_ptr(wr_ptr);
          if (rel_ok && !fifo_gnt)      count <= count + 1'b1;
          else if (!rel_ok && fifo_gnt) count <= count - 1'b1;
          bitmap    <= bitmap_nxt;
          dup_err_q <= dup_err_q | rel_dup;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // Storage carries no reset; INIT rewrites every entry before it is read.
  always_ff @(posedge SIG_CLK) begin
    if (state == S_INIT)  fifo[wr_ptr] <= init_id;
    else if (rel_ok)      fifo[wr_ptr] <= rel_id;
  end

endmodule

// File: tb/tb_phyreg_free_list.sv
// Scoreboard bench for phyreg_free_list: queue-based reference model predicts grants,
// a negedge monitor pops and compares whenever alloc_gnt is seen.
module tb_phyreg_free_list;

  localparam int NUM   = 128;
  localparam int ARCH  = 32;
  localparam int DEPTH = NUM - ARCH;

  logic       SIG_CLK;
  logic       SIG_RSTn;
  logic       alloc_req;
  logic       alloc_gnt;
  logic [6:0] alloc_id;
  logic       rel_valid;
  logic       rel_ready;
  logic [6:0] rel_id;
  logic [7:0] free_count;
  logic       init_done;
  logic       dup_err;

  phyreg_free_list dut (
    .SIG_CLK    (SIG_CLK),
    .SIG_RSTn   (SIG_RSTn),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .alloc_id   (alloc_id),
    .rel_valid  (rel_valid),
    .rel_ready  (rel_ready),
    .rel_id     (rel_id),
    .free_count (free_count),
    .init_done  (init_done),
    .dup_err    (dup_err)
  );

  initial SIG_CLK = 1'b0;
  always #5 SIG_CLK = ~SIG_CLK;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int fq[$];
  bit mfree [NUM];
  bit mrun;
  int minit;
  bit mdup;

  int exp_q[$];
  int got_q[$];
  int last_gnt = -1;
  int perm [DEPTH];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    fq.delete();
    for (int i = 0; i < NUM; i++) mfree[i] = 1'b0;
    mrun  = 1'b0;
    minit = 0;
    mdup  = 1'b0;
  endfunction

  function automatic void predict(input bit req, input bit rv, input int rid,
                                  output bit g, output int gid);
    g = 1'b0;
    gid = 0;
    if (!mrun) return;
    if (req && fq.size() > 0) begin
      g = 1'b1;
      gid = fq[0];
    end
`ifdef FREE_LIST_BYPASS_EN
    else if (req && rv && fq.size() == 0 && rid != 0 && !mfree[rid]) begin
      g = 1'b1;
      gid = rid;
    end
`endif
  endfunction

  function automatic void model_update(input bit req, input bit rv, input int rid);
    bit popped;
    bit bad;
    bit byp;
    int id;
    if (!mrun) begin
      fq.push_back(ARCH + minit);
      mfree[ARCH + minit] = 1'b1;
      minit++;
      if (minit == DEPTH) mrun = 1'b1;
      return;
    end
    popped = 1'b0;
    if (req && fq.size() > 0) begin
      id = fq.pop_front();
      mfree[id] = 1'b0;
      popped = 1'b1;
    end
    if (rv) begin
      bad = (rid == 0) || mfree[rid];
      byp = 1'b0;
`ifdef FREE_LIST_BYPASS_EN
      byp = !popped && req && fq.size() == 0 && !bad;
`endif
      if (byp) begin
        // consumed directly by the allocator, nothing stored
      end else if (bad || fq.size() == DEPTH) begin
        mdup = 1'b1;
      end else begin
        fq.push_back(rid);
        mfree[rid] = 1'b1;
      end
    end
  endfunction

  function automatic int pick_rid();
    int start;
    int id;
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NUM - 1));
    start = int'($urandom_range(1, NUM - 1));
    for (int k = 0; k < NUM; k++) begin
      id = (start + k) % NUM;
      if (id != 0 && !mfree[id]) return id;
    end
    return start;
  endfunction

  // Called just after a rising edge; occupies exactly one clock cycle.
  task automatic step(input bit req, input bit rv, input int rid);
    bit g;
    int gid;
    alloc_req = req;
    rel_valid = rv;
    rel_id    = rid[6:0];
    chk("free_count", free_count, fq.size());
    chk("dup_err", dup_err, mdup);
    chk("init_done", init_done, mrun);
    chk("rel_ready", rel_ready, mrun);
    predict(req, rv, rid, g, gid);
    if (g) exp_q.push_back(gid);
    @(posedge SIG_CLK);
    model_update(req, rv, rid);
    #1;
    chk("grant_missing", exp_q.size(), 0);
    exp_q.delete();
    alloc_req = 1'b0;
    rel_valid = 1'b0;
    rel_id    = '0;
  endtask

  task automatic apply_reset();
    alloc_req = 1'b1;
    rel_valid = 1'b1;
    rel_id    = 7'd9;
    SIG_RSTn  = 1'b0;
    #1;
    chk("rst_alloc_gnt", alloc_gnt, 0);
    chk("rst_alloc_id", alloc_id, 0);
    chk("rst_rel_ready", rel_ready, 0);
    chk("rst_free_count", free_count, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_dup_err", dup_err, 0);
    model_reset();
    exp_q.delete();
    @(posedge SIG_CLK);
    #1;
    chk("rst_hold_gnt", alloc_gnt, 0);
    chk("rst_hold_count", free_count, 0);
    alloc_req = 1'b0;
    rel_valid = 1'b0;
    rel_id    = '0;
    SIG_RSTn  = 1'b1;
  endtask

  always @(negedge SIG_CLK) begin
    if (alloc_gnt === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_gnt: alloc_id=%0d granted, expected no grant (t=%0t)", alloc_id, $time);
      end else begin
        chk("alloc_id", alloc_id, exp_q.pop_front());
      end
      last_gnt = int'(alloc_id);
      got_q.push_back(int'(alloc_id));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tmp;
    int j;
    SIG_RSTn  = 1'b0;
    alloc_req = 1'b0;
    rel_valid = 1'b0;
    rel_id    = '0;
    model_reset();
    @(posedge SIG_CLK);
    #1;
    apply_reset();

    // init: no grant while requesting, done after exactly DEPTH cycles
    repeat (DEPTH - 1) step(1, 0, 0);
    chk("init_not_done_yet", init_done, 0);
    step(1, 0, 0);
    chk("init_done_96", init_done, 1);
    chk("init_count_96", free_count, 96);

    repeat (3) step(1, 0, 0);
    chk("third_alloc_id", last_gnt, 34);
    chk("count_after_3", free_count, 93);

    repeat (93) step(1, 0, 0);
    chk("drain_last_id", last_gnt, 127);
    alloc_req = 1'b1;
    #2;
    chk("empty_no_gnt", alloc_gnt, 0);
    chk("empty_count", free_count, 0);
    alloc_req = 1'b0;

    step(0, 1, 40);
    step(1, 0, 0);
    chk("realloc_40", last_gnt, 40);

    chk("dup_clear_before", dup_err, 0);
    step(0, 1, 50);
    step(0, 1, 50);
    step(0, 1, 0);
    chk("dup_sticky", dup_err, 1);
    chk("dup_count_kept", free_count, 1);
    step(1, 0, 0);
    chk("realloc_50", last_gnt, 50);

    step(1, 1, 77);
`ifdef FREE_LIST_BYPASS_EN
    chk("bypass_id", last_gnt, 77);
    chk("bypass_count", free_count, 0);
`else
    chk("nobypass_count", free_count, 1);
    step(1, 0, 0);
    chk("nobypass_next_id", last_gnt, 77);
`endif

    // full list: release of a mapped ID is dropped; same-ID alloc+release is legal
    apply_reset();
    repeat (DEPTH) step(0, 0, 0);
    step(0, 1, 5);
    chk("full_dup", dup_err, 1);
    chk("full_count", free_count, 96);
    step(1, 1, 32);
    chk("same_id_gnt", last_gnt, 32);
    chk("same_id_count", free_count, 96);

    // wrap: drain, release in shuffled order, reallocate in that order
    got_q.delete();
    repeat (DEPTH) step(1, 0, 0);
    chk("wrap_drained", got_q.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) perm[i] = got_q[i];
    for (int i = DEPTH - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int i = 0; i < DEPTH; i++) step(0, 1, perm[i]);
    got_q.delete();
    repeat (100) step(1, 0, 0);
    chk("wrap_gnt_count", got_q.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < got_q.size(); i++) chk("wrap_order", got_q[i], perm[i]);
    chk("wrap_empty", free_count, 0);

    // random traffic with a reset mid-stream
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) apply_reset();
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), pick_rid());
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
